// File: rtl/pipe_hazard_unit_if.sv
// Pipeline-side bundle for the hazard controller: ID-stage decode fields,
// branch outcome, and the stall/flush/forward controls returned to the pipeline.
interface pipe_hazard_unit_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 16
);
    logic              id_valid_i;
    logic [ADDR_W-1:0] id_rs_i;
    logic [ADDR_W-1:0] id_rt_i;
    logic              id_use_rs_i;
    logic              id_use_rt_i;
    logic [ADDR_W-1:0] id_dst_i;
    logic              id_regwrite_i;
    logic              id_memread_i;
    logic              br_taken_i;

    logic              stall_o;
    logic              flush_if_id_o;
    logic              flush_id_ex_o;
    logic              flush_ex_mem_o;
    logic [1:0]        fwd_a_o;
    logic [1:0]        fwd_b_o;
    logic [CNT_W-1:0]  stall_cnt_o;
    logic [CNT_W-1:0]  flush_cnt_o;

    modport master (
        output id_valid_i, id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
               id_dst_i, id_regwrite_i, id_memread_i, br_taken_i,
        input  stall_o, flush_if_id_o, flush_id_ex_o, flush_ex_mem_o,
               fwd_a_o, fwd_b_o, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  id_valid_i, id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
               id_dst_i, id_regwrite_i, id_memread_i, br_taken_i,
        output stall_o, flush_if_id_o, flush_id_ex_o, flush_ex_mem_o,
               fwd_a_o, fwd_b_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/pipe_hazard_unit.sv
// Hazard controller for the five-stage pipeline: a three-entry scoreboard
// (EX/MEM/WB) of in-flight writers drives stall, branch flush and operand
// forwarding selects, plus saturating stall/flush event counters.
module pipe_hazard_unit #(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned BR_STAGE = 2,
    parameter int unsigned FWD_EN   = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk_i,
    input  logic              rst_n,
    pipe_hazard_unit_if.slave hz_if
);
    localparam bit BR_IN_MEM = (BR_STAGE == 2);
    localparam bit FWD_ON    = (FWD_EN != 0);

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] dst;
        logic              regwrite;
        logic              memread;
    } sb_entry_t;

    sb_entry_t         ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    logic [ADDR_W-1:0] ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic              br_taken;
    logic              stall;

    function automatic logic writer_match(input sb_entry_t e, input logic [ADDR_W-1:0] r);
        return e.valid && e.regwrite && (e.dst == r) && (r != '0);
    endfunction

    // With forwarding only a load directly ahead cannot be bypassed in time;
    // without it every in-flight writer blocks until it leaves WB.
    function automatic logic src_hazard(input sb_entry_t ex_e, input sb_entry_t mem_e,
                                        input sb_entry_t wb_e, input logic [ADDR_W-1:0] r);
        if (FWD_ON) begin
            return writer_match(ex_e, r) && ex_e.memread;
        end
        return writer_match(ex_e, r) || writer_match(mem_e, r) || writer_match(wb_e, r);
    endfunction

    function automatic logic [1:0] fwd_sel(input sb_entry_t mem_e, input sb_entry_t wb_e,
                                           input logic [ADDR_W-1:0] r);
        if (!FWD_ON) begin
            return 2'd0;
        end
        if (writer_match(mem_e, r) && !mem_e.memread) begin
            return 2'd1;
        end
        if (writer_match(wb_e, r)) begin
            return 2'd2;
        end
        return 2'd0;
    endfunction

    // Stall, flush and forwarding controls from ID inputs and registered scoreboard
    always_comb begin
        // Flushes are gated so they read 0 while reset is held; stall and
        // forwarding already fall to 0 with the cleared scoreboard.
        br_taken = hz_if.br_taken_i && rst_n;
        stall    = hz_if.id_valid_i && !br_taken &&
                   ((hz_if.id_use_rs_i && src_hazard(ex_q, mem_q, wb_q, hz_if.id_rs_i)) ||
                    (hz_if.id_use_rt_i && src_hazard(ex_q, mem_q, wb_q, hz_if.id_rt_i)));
        hz_if.stall_o        = stall;
        hz_if.flush_if_id_o  = br_taken;
        hz_if.flush_id_ex_o  = br_taken;
        hz_if.flush_ex_mem_o = br_taken && BR_IN_MEM;
        hz_if.fwd_a_o        = fwd_sel(mem_q, wb_q, ex_rs_q);
        hz_if.fwd_b_o        = fwd_sel(mem_q, wb_q, ex_rt_q);
        hz_if.stall_cnt_o    = stall_cnt_q;
        hz_if.flush_cnt_o    = flush_cnt_q;
    end

    // Scoreboard advance: entries shift one stage, bubbles inserted on stall/flush
    always_comb begin
        wb_d = mem_q;
        if (br_taken && BR_IN_MEM) begin
            mem_d = '0;
        end else begin
            mem_d = ex_q;
        end
        ex_d    = '0;
        ex_rs_d = '0;
        ex_rt_d = '0;
        if (hz_if.id_valid_i && !stall && !br_taken) begin
            ex_d.valid    = 1'b1;
            ex_d.dst      = hz_if.id_dst_i;
            ex_d.regwrite = hz_if.id_regwrite_i;
            ex_d.memread  = hz_if.id_memread_i;
            ex_rs_d       = hz_if.id_rs_i;
            ex_rt_d       = hz_if.id_rt_i;
        end
    end

    // Saturating event counters
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (br_taken && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            ex_rs_q     <= '0;
            ex_rt_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            ex_rs_q     <= ex_rs_d;
            ex_rt_q     <= ex_rt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end
endmodule
